orbit_pixel_plotter: RTL

//  Sink for the orbital solver's position stream. Accepts one (X,Y) IEEE-754 single-precision sample per handshake.

---
 rtl/orbit_pixel_plotter_if.sv | 26 ++
 rtl/orbit_pixel_plotter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/orbit_pixel_plotter_if.sv
// Bus bundle for orbit_pixel_plotter: the incoming (X,Y) sample stream
// and the framebuffer write/ack port.
// master : plotter side (accepts samples, issues framebuffer writes)
// slave  : environment side (sample source and framebuffer)
interface orbit_pixel_plotter_if #(
   parameter int ADDR_W = 19
) ();
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_x;
   logic [31:0]       in_y;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_ack;

   modport master (
      input  in_valid, in_x, in_y, mem_ack,
      output in_ready, mem_we, mem_addr, mem_data
   );

   modport slave (
      output in_valid, in_x, in_y, mem_ack,
      input  in_ready, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/orbit_pixel_plotter.sv
// orbit_pixel_plotter
// Takes IEEE-754 single (X,Y) samples, truncates them to 32-bit signed
// integers, scales to screen pixels (centre origin, +Y up), clips, and
// plots one pixel per on-screen sample through a write/ack framebuffer port.
// Optional feature macro: TRAIL_ERASE_EN -- keeps a ring of the last
// TRAIL_LEN plotted addresses and erases the oldest pixel once the ring is
// full, so only TRAIL_LEN pixels stay lit.
module orbit_pixel_plotter #(
   parameter int         SCR_W     = 640,
   parameter int         SCR_H     = 480,
   parameter int         SHIFT     = 16,
   parameter int         ADDR_W    = 19,
   parameter logic [7:0] COLOR     = 8'hFF,
   parameter logic [7:0] BG        = 8'h00,
   parameter int         TRAIL_LEN = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   orbit_pixel_plotter_if.master bus,
   output logic [15:0]           drop_cnt,
   output logic                  busy
);

`ifdef TRAIL_ERASE_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CONV  = 3'd1,
      ST_SCALE = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERASE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CONV  = 3'd1,
      ST_SCALE = 3'd2,
      ST_WRITE = 3'd3
   } state_t;
`endif

   localparam logic signed [32:0] HALF_W_S = 33'(SCR_W / 2);
   localparam logic signed [32:0] HALF_H_S = 33'(SCR_H / 2);
   localparam logic signed [32:0] W_MAX_S  = 33'(SCR_W - 1);
   localparam logic signed [32:0] H_MAX_S  = 33'(SCR_H - 1);
   localparam logic signed [32:0] SCR_W_S  = 33'(SCR_W);

`ifdef TRAIL_ERASE_EN
   localparam int PTR_W = (TRAIL_LEN > 1) ? $clog2(TRAIL_LEN) : 1;
   localparam logic [PTR_W:0] RING_FULL = (PTR_W + 1)'(TRAIL_LEN);
`endif

   // Float to integer, truncating toward zero; bit 32 flags Inf/NaN.
   function automatic logic [32:0] fp_to_int(input logic [31:0] f);
      logic [7:0]  e;
      logic [31:0] m;
      logic [31:0] mag;
      logic        inv;
      e   = f[30:23];
      m   = {8'h00, 1'b1, f[22:0]};
      inv = 1'b0;
      if (e == 8'd255) begin
         inv = 1'b1;
         mag = 32'd0;
      end else if (e >= 8'd158) begin
         mag = 32'h7FFF_FFFF;
      end else if (e >= 8'd150) begin
         mag = m << (e - 8'd150);
      end else if (e >= 8'd127) begin
         mag = m >> (8'd150 - e);
      end else begin
         mag = 32'd0;
      end
      return {inv, (f[31] ? (32'd0 - mag) : mag)};
   endfunction

   state_t             state_r;
   logic [31:0]        x_r;
   logic [31:0]        y_r;
   logic signed [31:0] xi_r;
   logic signed [31:0] yi_r;
   logic               inv_r;
   logic               in_ready_r;
   logic               mem_we_r;
   logic [ADDR_W-1:0]  mem_addr_r;
   logic [7:0]         mem_data_r;
   logic [15:0]        drop_cnt_r;
   logic               busy_r;

   logic [32:0]        conv_x_s;
   logic [32:0]        conv_y_s;
   logic signed [31:0] xi_sh_s;
   logic signed [31:0] yi_sh_s;
   logic signed [32:0] px_s;
   logic signed [32:0] py_s;
   logic signed [32:0] addr_full_s;
   logic               on_screen_s;

`ifdef TRAIL_ERASE_EN
   logic [ADDR_W-1:0]  ring_r [TRAIL_LEN];
   logic [PTR_W-1:0]   ring_ptr_r;
   logic [PTR_W:0]     ring_cnt_r;
`endif

   assign bus.in_ready = in_ready_r;
   assign bus.mem_we   = mem_we_r;
   assign bus.mem_addr = mem_addr_r;
   assign bus.mem_data = mem_data_r;
   assign drop_cnt     = drop_cnt_r;
   assign busy         = busy_r;

   // Conversion of the latched sample and pixel/address computation for SCALE.
   always_comb begin
      conv_x_s    = fp_to_int(x_r);
      conv_y_s    = fp_to_int(y_r);
      xi_sh_s     = xi_r >>> SHIFT;
      yi_sh_s     = yi_r >>> SHIFT;
      px_s        = {xi_sh_s[31], xi_sh_s} + HALF_W_S;
      py_s        = HALF_H_S - {yi_sh_s[31], yi_sh_s};
      addr_full_s = (py_s * SCR_W_S) + px_s;
      if (!inv_r && (px_s >= 33'sd0) && (px_s <= W_MAX_S) &&
          (py_s >= 33'sd0) && (py_s <= H_MAX_S)) begin
         on_screen_s = 1'b1;
      end else begin
         on_screen_s = 1'b0;
      end
   end

   // Main FSM with registered handshake, framebuffer and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         x_r        <= 32'd0;
         y_r        <= 32'd0;
         xi_r       <= 32'sd0;
         yi_r       <= 32'sd0;
         inv_r      <= 1'b0;
         in_ready_r <= 1'b1;
         mem_we_r   <= 1'b0;
         mem_addr_r <= '0;
         mem_data_r <= 8'h00;
         drop_cnt_r <= 16'd0;
         busy_r     <= 1'b0;
`ifdef TRAIL_ERASE_EN
         ring_ptr_r <= '0;
         ring_cnt_r <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  x_r        <= bus.in_x;
                  y_r        <= bus.in_y;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_CONV;
               end
            end
            ST_CONV: begin
               xi_r    <= conv_x_s[31:0];
               yi_r    <= conv_y_s[31:0];
               inv_r   <= conv_x_s[32] | conv_y_s[32];
               state_r <= ST_SCALE;
            end
            ST_SCALE: begin
               if (on_screen_s) begin
                  mem_addr_r <= addr_full_s[ADDR_W-1:0];
                  mem_data_r <= COLOR;
                  mem_we_r   <= 1'b1;
                  state_r    <= ST_WRITE;
               end else begin
                  if (drop_cnt_r != 16'hFFFF) begin
                     drop_cnt_r <= drop_cnt_r + 16'd1;
                  end
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (bus.mem_ack) begin
                  mem_we_r <= 1'b0;
`ifdef TRAIL_ERASE_EN
                  // When full, the slot under the pointer is the oldest pixel:
                  // it is read out for erasing and overwritten with the new one.
                  ring_r[ring_ptr_r] <= mem_addr_r;
                  ring_ptr_r         <= ring_ptr_r + 1'b1;
                  if (ring_cnt_r == RING_FULL) begin
                     mem_addr_r <= ring_r[ring_ptr_r];
                     mem_data_r <= BG;
                     state_r    <= ST_ERASE;
                  end else begin
                     ring_cnt_r <= ring_cnt_r + 1'b1;
                     in_ready_r <= 1'b1;
                     busy_r     <= 1'b0;
                     state_r    <= ST_IDLE;
                  end
`else
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
`endif
               end
            end
`ifdef TRAIL_ERASE_EN
            ST_ERASE: begin
               // First ERASE cycle keeps mem_we low to separate it from the plot write.
               if (!mem_we_r) begin
                  mem_we_r <= 1'b1;
               end else if (bus.mem_ack) begin
                  mem_we_r   <= 1'b0;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            end
`endif
            default: begin
               mem_we_r   <= 1'b0;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
